// File: rtl/i2c_simple_master_if.sv
// i2c_simple_master_if
//   Bundles the command/response handshake and the open-drain pin controls of
//   the single-byte I2C master.
//   master modport : the controller (drives pulldowns, cmd_ready, rsp_*).
//   slave  modport : the user side plus pin primitives (drives cmd_*, *_di).
//   Pin side : scl_di/sda_di = synchronized line levels, *_pulldown = 1 pulls low.
//   Command  : cmd_valid/cmd_ready, cmd_addr[6:0], cmd_rw, cmd_wdata[7:0].
//   Response : rsp_valid pulse, rsp_rdata[7:0], rsp_nack; busy; debug_state[3:0].
interface i2c_simple_master_if;
  logic       scl_di;
  logic       sda_di;
  logic       scl_pulldown;
  logic       sda_pulldown;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [6:0] cmd_addr;
  logic       cmd_rw;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_nack;
  logic       busy;
  logic [3:0] debug_state;

  modport master (
    input  scl_di, sda_di, cmd_valid, cmd_addr, cmd_rw, cmd_wdata,
    output scl_pulldown, sda_pulldown, cmd_ready, rsp_valid, rsp_rdata,
           rsp_nack, busy, debug_state
  );

  modport slave (
    output scl_di, sda_di, cmd_valid, cmd_addr, cmd_rw, cmd_wdata,
    input  scl_pulldown, sda_pulldown, cmd_ready, rsp_valid, rsp_rdata,
           rsp_nack, busy, debug_state
  );
endinterface

// File: rtl/i2c_simple_master.sv
// i2c_simple_master
//   One command = START, {addr, rw}, one data byte, STOP on the I2C bus.
//   Every bus step is one quarter of an SCL period (CLK_DIV clk cycles).
//   Ports:
//     clk, rst_n : system clock, asynchronous active-low reset
//     io         : i2c_simple_master_if.master (pins, command, response)
//   Parameter:
//     CLK_DIV    : clk cycles per SCL quarter-period, 2..65535
module i2c_simple_master #(
  parameter int unsigned CLK_DIV = 30
) (
  input logic                 clk,
  input logic                 rst_n,
  i2c_simple_master_if.master io
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_BUSFREE  = 4'd1,
    S_START    = 4'd2,
    S_ADDR     = 4'd3,
    S_ADDR_ACK = 4'd4,
    S_DATA     = 4'd5,
    S_DATA_ACK = 4'd6,
    S_STOP     = 4'd7,
    S_DONE     = 4'd8
  } state_e;

  localparam logic [15:0] QLAST = 16'(CLK_DIV - 1);

  state_e      state_q, state_d;
  logic [15:0] tmr_q, tmr_d;
  logic [2:0]  qtr_q, qtr_d;       // quarter inside START / bit slot / STOP
  logic [2:0]  bit_q, bit_d;       // bits left in current byte
  logic [7:0]  tx_q, tx_d;         // outgoing byte, MSB on the wire
  logic [7:0]  rx_q, rx_d;
  logic        rw_q, rw_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        nack_q, nack_d;
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;
  logic        rsp_nack_q, rsp_nack_d;
  logic        scl_pd_q, scl_pd_d;
  logic        sda_pd_q, sda_pd_d;

  logic accept, in_slot, freeze, lines_idle, tick;

  assign accept     = (state_q == S_IDLE) && io.cmd_valid;
  assign lines_idle = io.scl_di && io.sda_di;
  // STOP quarters 4,5 are the post-STOP hold, not part of a bit slot
  assign in_slot    = (state_q inside {S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_STOP})
                      && (qtr_q < 3'd4);
  // clock stretching: SCL released by us but still seen low
  assign freeze     = in_slot && (qtr_q == 3'd2) && !io.scl_di;
  assign tick       = (tmr_q == QLAST) && !freeze
                      && !((state_q == S_BUSFREE) && !lines_idle);

  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    qtr_d       = qtr_q;
    bit_d       = bit_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    rw_d        = rw_q;
    wdata_d     = wdata_q;
    nack_d      = nack_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_nack_d  = rsp_nack_q;

    // quarter timer; BUSFREE restarts the quarter whenever a line is low
    if (state_q inside {S_IDLE, S_DONE})                 tmr_d = '0;
    else if ((state_q == S_BUSFREE) && !lines_idle)      tmr_d = '0;
    else if (tick)                                       tmr_d = '0;
    else if (!freeze)                                    tmr_d = tmr_q + 16'd1;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_BUSFREE;
          tx_d    = {io.cmd_addr, io.cmd_rw};
          rw_d    = io.cmd_rw;
          wdata_d = io.cmd_wdata;
          rx_d    = '0;
          nack_d  = 1'b0;
        end
      end
      S_BUSFREE: begin
        if (tick) begin
          state_d = S_START;
          qtr_d   = '0;
        end
      end
      S_START: begin
        if (tick) begin
          if (qtr_q == 3'd1) begin
            state_d = S_ADDR;
            qtr_d   = '0;
            bit_d   = 3'd7;
          end else begin
            qtr_d = qtr_q + 3'd1;
          end
        end
      end
      S_ADDR, S_DATA: begin
        if (tick) begin
          if (qtr_q != 3'd3) begin
            qtr_d = qtr_q + 3'd1;
          end else begin
            qtr_d = '0;
            if ((state_q == S_DATA) && rw_q) rx_d = {rx_q[6:0], io.sda_di};
            tx_d = {tx_q[6:0], 1'b1};
            if (bit_q == 3'd0) state_d = (state_q == S_ADDR) ? S_ADDR_ACK : S_DATA_ACK;
            else               bit_d   = bit_q - 3'd1;
          end
        end
      end
      S_ADDR_ACK: begin
        if (tick) begin
          if (qtr_q != 3'd3) begin
            qtr_d = qtr_q + 3'd1;
          end else begin
            qtr_d = '0;
            if (io.sda_di) begin
              nack_d  = 1'b1;
              state_d = S_STOP;
            end else begin
              state_d = S_DATA;
              bit_d   = 3'd7;
              // all ones keeps SDA released while the slave drives read data
              tx_d    = rw_q ? 8'hFF : wdata_q;
            end
          end
        end
      end
      S_DATA_ACK: begin
        if (tick) begin
          if (qtr_q != 3'd3) begin
            qtr_d = qtr_q + 3'd1;
          end else begin
            qtr_d   = '0;
            if (!rw_q && io.sda_di) nack_d = 1'b1;
            state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (qtr_q == 3'd5) begin
            state_d     = S_DONE;
            rsp_rdata_d = rw_q ? rx_q : 8'h00;
            rsp_nack_d  = nack_q;
          end else begin
            qtr_d = qtr_q + 3'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // pin drive decoded from next state so the pulldowns come straight off flops
    scl_pd_d = 1'b0;
    sda_pd_d = 1'b0;
    case (state_d)
      S_START: sda_pd_d = 1'b1;
      S_ADDR, S_DATA: begin
        scl_pd_d = (qtr_d < 3'd2);
        sda_pd_d = ~tx_d[7];
      end
      S_ADDR_ACK, S_DATA_ACK: scl_pd_d = (qtr_d < 3'd2);
      S_STOP: begin
        scl_pd_d = (qtr_d < 3'd2);
        sda_pd_d = (qtr_d < 3'd4);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tmr_q       <= '0;
      qtr_q       <= '0;
      bit_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      rw_q        <= 1'b0;
      wdata_q     <= '0;
      nack_q      <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_nack_q  <= 1'b0;
      scl_pd_q    <= 1'b0;
      sda_pd_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      qtr_q       <= qtr_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rw_q        <= rw_d;
      wdata_q     <= wdata_d;
      nack_q      <= nack_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_nack_q  <= rsp_nack_d;
      scl_pd_q    <= scl_pd_d;
      sda_pd_q    <= sda_pd_d;
    end
  end

  assign io.scl_pulldown = scl_pd_q;
  assign io.sda_pulldown = sda_pd_q;
  assign io.cmd_ready    = (state_q == S_IDLE);
  assign io.rsp_valid    = (state_q == S_DONE);
  assign io.rsp_rdata    = rsp_rdata_q;
  assign io.rsp_nack     = rsp_nack_q;
  // the accept cycle itself already counts as busy
  assign io.busy         = (state_q != S_IDLE) || io.cmd_valid;
  assign io.debug_state  = state_q;

endmodule

// File: tb/tb_i2c_simple_master.sv
// tb_i2c_simple_master
//   Bus-level slave model plus expected results derived from transaction
//   parameters (quarter counts, ack decisions, stretch and busy-bus delays).
module tb_i2c_simple_master;
  localparam int CD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  i2c_simple_master_if bus();
  i2c_simple_master #(.CLK_DIV(CD)) dut (.clk(clk), .rst_n(rst_n), .io(bus));

  // open-drain wired-AND of master, slave model and an external SDA holder
  logic slv_scl_hold = 1'b0, slv_sda_pd = 1'b0, ext_sda = 1'b0, slv_clr = 1'b0;
  assign bus.scl_di = ~(bus.scl_pulldown | slv_scl_hold);
  assign bus.sda_di = ~(bus.sda_pulldown | slv_sda_pd | ext_sda);

  // slave configuration (set by the stimulus) and captures (set by the model)
  logic       cfg_ack_a = 1'b1, cfg_ack_d = 1'b1;
  logic [7:0] cfg_rbyte = 8'h00;
  int         cfg_stretch = 0;
  logic [8:0] cap_addr = 9'h1FF, cap_wdata = 9'h1FF;

  logic       p_scl = 1'b1, p_sda = 1'b1, s_scl, s_sda;
  logic       active = 1'b0, in_data = 1'b0, acked = 1'b0, is_rd = 1'b0;
  logic [7:0] sh = 8'h00;
  int         bitcnt = 0, scnt = 0;

  always @(negedge clk) begin
    s_scl = bus.scl_di;
    s_sda = bus.sda_di;
    if (slv_clr) begin
      active = 1'b0; slv_sda_pd = 1'b0; slv_scl_hold = 1'b0;
    end else begin
      if (s_scl && p_scl && p_sda && !s_sda) begin
        active = 1'b1; in_data = 1'b0; bitcnt = 0; sh = 8'h00; acked = 1'b0;
        slv_sda_pd = 1'b0; cap_addr = 9'h1FF; cap_wdata = 9'h1FF; scnt = 0;
      end else if (s_scl && p_scl && !p_sda && s_sda) begin
        active = 1'b0; slv_sda_pd = 1'b0;
      end else if (active) begin
        if (!p_scl && s_scl) begin
          sh = {sh[6:0], s_sda};
          bitcnt++;
        end else if (p_scl && !s_scl) begin
          if (!in_data) begin
            if (bitcnt == 2 && cfg_stretch > 0) begin slv_scl_hold = 1'b1; scnt = 0; end
            if (bitcnt == 8) begin
              cap_addr = {1'b0, sh}; is_rd = sh[0]; acked = cfg_ack_a; slv_sda_pd = cfg_ack_a;
            end
            if (bitcnt == 9) begin
              slv_sda_pd = 1'b0; in_data = 1'b1; bitcnt = 0;
              if (acked && is_rd) slv_sda_pd = ~cfg_rbyte[7];
            end
          end else if (!is_rd) begin
            if (bitcnt == 8) begin cap_wdata = {1'b0, sh}; slv_sda_pd = cfg_ack_d; end
            if (bitcnt == 9) slv_sda_pd = 1'b0;
          end else begin
            if (acked && bitcnt >= 1 && bitcnt <= 7) slv_sda_pd = ~cfg_rbyte[7-bitcnt];
            if (bitcnt == 8) slv_sda_pd = 1'b0;
          end
        end
      end
      // hold SCL low for cfg_stretch cycles once the master has let go of it
      if (slv_scl_hold && !bus.scl_pulldown) begin
        if (scnt == cfg_stretch) slv_scl_hold = 1'b0;
        else scnt++;
      end
    end
    p_scl = s_scl;
    p_sda = s_sda;
  end

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Entered and left on a falling clk edge; issues the command immediately,
  // so consecutive calls exercise back-to-back acceptance.
  task automatic run_txn(input logic [6:0] a, input logic rw, input logic [7:0] wd,
                         input logic [7:0] rb, input logic ack_a, input logic ack_d,
                         input int stretch, input int hold);
    int n, exp_lat;
    logic quiet, exp_nack;
    logic [7:0] exp_rd;
    cfg_ack_a = ack_a; cfg_ack_d = ack_d; cfg_rbyte = rb; cfg_stretch = stretch;
    exp_lat  = (ack_a ? 81 : 45) * CD + 1 + stretch + hold;
    exp_nack = !ack_a || (!rw && !ack_d);
    exp_rd   = (rw && ack_a) ? rb : 8'h00;
    if (hold > 0) ext_sda = 1'b1;
    bus.cmd_valid = 1'b1; bus.cmd_addr = a; bus.cmd_rw = rw; bus.cmd_wdata = wd;
    #1;
    chk("ready_at_issue", 32'(bus.cmd_ready), 32'd1);
    chk("busy_at_accept", 32'(bus.busy), 32'd1);
    quiet = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        bus.cmd_valid = 1'b0;
        bus.cmd_addr = 7'($urandom); bus.cmd_rw = 1'($urandom); bus.cmd_wdata = 8'($urandom);
      end
      if (ext_sda && (bus.scl_pulldown || bus.sda_pulldown)) quiet = 1'b0;
      if (n == hold + 1) ext_sda = 1'b0;
    end while (!bus.rsp_valid && n < exp_lat + 200);
    chk("rsp_seen", 32'(bus.rsp_valid), 32'd1);
    chk("latency", 32'(n), 32'(exp_lat));
    chk("rsp_nack", 32'(bus.rsp_nack), 32'(exp_nack));
    chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_rd));
    chk("busy_at_rsp", 32'(bus.busy), 32'd1);
    chk("addr_on_bus", 32'(cap_addr), {23'd0, 2'b00, a, rw});
    chk("wdata_on_bus", 32'(cap_wdata), (!rw && ack_a) ? {23'd0, 1'b0, wd} : 32'h1FF);
    if (hold > 0) chk("quiet_on_busy_bus", 32'(quiet), 32'd1);
    @(negedge clk);
    chk("ready_after", 32'(bus.cmd_ready), 32'd1);
    chk("rsp_pulse", 32'(bus.rsp_valid), 32'd0);
    chk("busy_after", 32'(bus.busy), 32'd0);
    chk("rdata_held", 32'(bus.rsp_rdata), 32'(exp_rd));
    chk("nack_held", 32'(bus.rsp_nack), 32'(exp_nack));
  endtask

  initial begin
    logic seen;
    int st, hd;
    bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_rw = 1'b0; bus.cmd_wdata = '0;
    #23;
    chk("rst_scl_pd", 32'(bus.scl_pulldown), 32'd0);
    chk("rst_sda_pd", 32'(bus.sda_pulldown), 32'd0);
    chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rdata", 32'(bus.rsp_rdata), 32'd0);
    chk("rst_nack", 32'(bus.rsp_nack), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(7'h42, 1'b0, 8'h5A, 8'h00, 1'b1, 1'b1, 0, 0);   // plain write
    run_txn(7'h42, 1'b1, 8'h00, 8'hC3, 1'b1, 1'b1, 0, 0);   // read 0xC3
    run_txn(7'h10, 1'b0, 8'h77, 8'h00, 1'b0, 1'b1, 0, 0);   // address NACK
    run_txn(7'h10, 1'b1, 8'h00, 8'hA5, 1'b0, 1'b1, 0, 0);   // read, address NACK
    run_txn(7'h42, 1'b0, 8'h5A, 8'h00, 1'b1, 1'b1, 50, 0);  // stretch 50
    run_txn(7'h42, 1'b0, 8'h3C, 8'h00, 1'b1, 1'b1, 0, 12);  // SDA held low
    run_txn(7'h33, 1'b0, 8'hE1, 8'h00, 1'b1, 1'b0, 0, 0);   // data NACK

    // reset in the middle of the data byte
    bus.cmd_valid = 1'b1; bus.cmd_addr = 7'h42; bus.cmd_rw = 1'b0; bus.cmd_wdata = 8'h96;
    cfg_ack_a = 1'b1; cfg_ack_d = 1'b1; cfg_stretch = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (42 * CD) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_scl_pd", 32'(bus.scl_pulldown), 32'd0);
    chk("arst_sda_pd", 32'(bus.sda_pulldown), 32'd0);
    chk("arst_ready", 32'(bus.cmd_ready), 32'd1);
    slv_clr = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1'b1;
    end
    rst_n = 1'b1;
    slv_clr = 1'b0;
    repeat (3 * CD) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1'b1;
    end
    chk("no_rsp_after_reset", 32'(seen), 32'd0);
    chk("ready_after_reset", 32'(bus.cmd_ready), 32'd1);
    run_txn(7'h42, 1'b0, 8'h96, 8'h00, 1'b1, 1'b1, 0, 0);

    for (int i = 0; i < 10; i++) begin
      st = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 40)) : 0;
      hd = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 20)) : 0;
      run_txn(7'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
              ($urandom_range(0, 4) != 0), ($urandom_range(0, 3) != 0), st, hd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_simple_master.md
# i2c_simple_master

Single-byte I2C controller that drives the peripheral I2C bus (PERIPH_SDA/PERIPH_SCL) through the existing open-drain pin primitives. It is the initiator counterpart to i2c_simple_slave. Each accepted command performs one complete transaction: START, 7-bit address plus R/W, one data byte, STOP. The result is reported as a one-cycle response strobe. Multi-master arbitration and repeated START are out of scope.

## Interface
- CLK_DIV, 30: clk cycles per SCL quarter-period (12 MHz / (4×30) = 100 kHz); legal range 2..65535.
- clk  in  1  system clock (ICE_CLK).
- rst_n  in  1  asynchronous, active-low reset.
- scl_di  in  1  synchronized SCL level from pin primitive.
- sda_di  in  1  synchronized SDA level from pin primitive.
- scl_pulldown  out  1  1 = drive SCL low, 0 = release.
- sda_pulldown  out  1  1 = drive SDA low, 0 = release.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; command accepted on cmd_valid & cmd_ready.
- cmd_addr  in  7  target address.
- cmd_rw  in  1  0 = write, 1 = read.
- cmd_wdata  in  8  byte to write (ignored for reads).
- rsp_valid  out  1  one-cycle pulse at transaction end.
- rsp_rdata  out  8  byte read (0x00 for writes and on address NACK); held until next rsp_valid.
- rsp_nack  out  1  1 = address or write-data NACK seen; held until next rsp_valid.
- busy  out  1  high from accept cycle until the rsp_valid cycle inclusive.
- debug_state  out  4  current FSM state encoding.

## Operation
- Command fields are latched on the accept cycle; input changes afterwards have no effect.
- FSM states: IDLE, BUSFREE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP, DONE.
- Quarter timer: counts CLK_DIV cycles; each state step advances on quarter expiry.
- BUSFREE: both lines released. Proceed only when a full quarter is observed with scl_di = sda_di = 1; otherwise restart the quarter.
- START: sda_pulldown = 1 with SCL released for 2 quarters. Then scl_pulldown = 1.
- Bit slot (ADDR, DATA, both ACK states), 4 quarters:
  - Q0, Q1: SCL low; SDA set at start of Q0.
  - Q2: SCL released; the timer stays frozen while scl_di = 0 (clock stretching).
  - Q3: SCL high; sda_di is sampled on the last cycle of Q3.
- ADDR: sends {cmd_addr, cmd_rw}, MSB first. ADDR_ACK: SDA released; sampled 1 = NACK → sets rsp_nack and goes to STOP, skipping DATA.
- Write: DATA sends cmd_wdata MSB first. DATA_ACK: SDA released; sampled 1 sets rsp_nack.
- Read: DATA releases SDA and shifts sda_di into rsp_rdata MSB first. DATA_ACK: master releases SDA (NACK = end of read). rsp_nack is not set.
- STOP: bit slot with SDA low (stretch honoured), then release SDA and hold 2 quarters.
- DONE: pulse rsp_valid for one cycle → IDLE.
- Reset values: scl_pulldown = 0, sda_pulldown = 0, cmd_ready = 1, rsp_valid = 0, rsp_rdata = 0x00, rsp_nack = 0, busy = 0, state IDLE.
- Reset asserted mid-transaction releases both lines immediately (asynchronous) and no response is issued.

## Timing
- SDA changes only while SCL is driven low, except the START and STOP edges.
- Uncontended, unstretched transaction: 3 quarters (BUSFREE + START) + 36 (addr + ack) + 36 (data + ack) + 6 (STOP) = 81 quarters.
- rsp_valid asserts exactly 81×CLK_DIV + 1 cycles after the accept cycle.
- Address NACK: 45×CLK_DIV + 1 cycles.
- Each stretched clk cycle (scl_di low in Q2) adds exactly one cycle.
- A busy bus at BUSFREE delays START until a clean idle quarter is seen.
- cmd_ready returns high the cycle after rsp_valid. A back-to-back command may be accepted on that cycle.

## Test plan
- Write 0x5A to address 0x42, slave ACKs both bytes → SDA bit sequence 1000010_0, ack, 01011010, ack; rsp_nack = 0; rsp_valid at 81×CLK_DIV + 1 (CLK_DIV = 4 → cycle 325).
- Read from 0x42, slave returns 0xC3 → address byte 0x85 on bus; master releases SDA in the 9th data slot; rsp_rdata = 0xC3, rsp_nack = 0.
- Address 0x10 with no slave responding (SDA pulled up) → rsp_nack = 1, rsp_rdata = 0x00, STOP issued, rsp_valid at 45×CLK_DIV + 1.
- Slave holds SCL low for 50 cycles during the 3rd address bit → total latency increases by exactly 50; data remains correct.
- SDA held low externally when the command is issued → scl_pulldown and sda_pulldown stay 0 until SDA has been released for a quarter, then START proceeds.
- rst_n asserted during DATA → both pulldowns are 0 asynchronously, no rsp_valid, cmd_ready = 1 after release; the next command completes normally.
